calc_ctrl: RTL and testbench
============================

Name: calc_ctrl

Overview:
- Sequencing controller between the debounced front-panel pulses and the calculator arithmetic unit.
- Owns the operation select (scroll up/down with wrap), latches operands on enter, and issues a one-cycle start to the ALU.
- Waits for the ALU's done with a timeout, then holds the result or an error code for the display driver.

Parameters:
- DATA_W, 4, operand width (a, b)
- RES_W, 8, ALU result width
- NUM_OPS, 8, number of valid op codes; op_sel wraps modulo NUM_OPS; must be 2..8
- TIMEOUT, 16, max cycles in WAIT before declaring a timeout error; must be >= 2

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- a  in  DATA_W  operand A switches
- b  in  DATA_W  operand B switches
- enter_p  in  1  debounced single-cycle pulse
- clear_p  in  1  debounced single-cycle pulse
- up_p  in  1  debounced single-cycle pulse
- down_p  in  1  debounced single-cycle pulse
- alu_a  out  DATA_W  latched operand A
- alu_b  out  DATA_W  latched operand B
- alu_op  out  3  latched op code
- alu_start  out  1  one-cycle start strobe
- alu_done  in  1  ALU completion strobe; result and error valid in the same cycle
- alu_result  in  RES_W  ALU result
- alu_err  in  1  ALU error, e.g. divide by zero
- op_sel  out  3  currently selected op code (live)
- busy  out  1  high in ISSUE and WAIT
- disp_mode  out  2  0 = show op_sel, 1 = show result, 2 = show error
- disp_val  out  RES_W  value for the display: result, or error code (1 = ALU error, 2 = timeout)

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
- Reset values, all outputs: op_sel=0, alu_a/b/op=0, alu_start=0, busy=0, disp_mode=0, disp_val=0, state=IDLE, timeout counter=0.
- Reset asserted mid-operation aborts immediately. A late alu_done after reset is ignored because the state is IDLE.
- All outputs are registered.
- States:
  - IDLE: display shows the op code.
  - ISSUE: single cycle; alu_start=1.
  - WAIT: counting cycles; waiting for alu_done.
  - SHOW: holding the result.
  - ERR: holding an error code.
- Priority within a cycle: clear_p > enter_p > up_p/down_p.
- clear_p, any state: next state IDLE, disp_mode=0, disp_val=0, counter=0. op_sel is retained.
  - From WAIT, the ALU is abandoned and a subsequent alu_done is ignored.
- enter_p in IDLE, SHOW or ERR:
  - Latch alu_a<=a, alu_b<=b, alu_op<=op_sel; go to ISSUE.
  - An up_p/down_p pulse in the same cycle is ignored.
- enter_p in ISSUE or WAIT: ignored.
- ISSUE -> WAIT unconditionally after one cycle. alu_start is high for exactly that cycle.
- WAIT, per cycle:
  - alu_done=1 and alu_err=0: SHOW, disp_mode=1, disp_val=alu_result.
  - alu_done=1 and alu_err=1: ERR, disp_mode=2, disp_val=1.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 with no done: ERR, disp_val=2.
  - Counter is cleared on leaving WAIT.
- alu_done outside WAIT: ignored.
- Scrolling (up_p/down_p) is accepted only in IDLE, SHOW and ERR.
  - up_p: op_sel = (op_sel+1) mod NUM_OPS, so NUM_OPS-1 wraps to 0.
  - down_p: 0 wraps to NUM_OPS-1.
  - up_p and down_p together: no change.
  - Scrolling in SHOW or ERR returns to IDLE with disp_mode=0.
- Latency:
  - enter_p to alu_start is 1 cycle.
  - alu_done to disp_mode/disp_val update is 1 cycle.
  - Scroll pulse to op_sel update is 1 cycle.
- busy=1 exactly in ISSUE and WAIT.

Test Plan:
- Reset then 9 up_p pulses (NUM_OPS=8) -> op_sel=1. Then 2 down_p -> op_sel=7 (wrap through 0).
- op_sel=2, a=5, b=3, enter_p -> alu_start high for 1 cycle with alu_op=2, alu_a=5, alu_b=3. ALU model returns done after 4 cycles, result=8 -> disp_mode=1, disp_val=8, busy=0.
- Operand change during WAIT: toggle a to 9 while in WAIT -> alu_a stays 5. An enter_p pulse during WAIT does not produce a second alu_start.
- ALU returns done with err=1 -> disp_mode=2, disp_val=1. Then up_p -> disp_mode=0, op_sel incremented.
- ALU never responds (TIMEOUT=16) -> ERR with disp_val=2, reached exactly 16 cycles after alu_start deasserts. A late alu_done after that produces no change.
- clear_p and enter_p in the same cycle from SHOW -> IDLE, no alu_start.
- rst_n low for 1 cycle in WAIT -> all outputs reset immediately (asynchronously). op_sel=0.

Source files
------------

// File: rtl/calc_ctrl.sv
// calc_ctrl: front-panel sequencing controller for the calculator ALU.
// Owns the op selection, latches operands on enter, fires a one-cycle
// start strobe, waits for the ALU with a timeout and then holds either the
// result or an error code for the display driver. Every output is a register.
module calc_ctrl #(
  parameter int DATA_W  = 4,
  parameter int RES_W   = 8,
  parameter int NUM_OPS = 8,   // 2..8
  parameter int TIMEOUT = 16   // >= 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              enter_p,
  input  logic              clear_p,
  input  logic              up_p,
  input  logic              down_p,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic [RES_W-1:0]  alu_result,
  input  logic              alu_err,
  output logic [2:0]        op_sel,
  output logic              busy,
  output logic [1:0]        disp_mode,
  output logic [RES_W-1:0]  disp_val
);

  // Counter only has to reach TIMEOUT-1.
  localparam int CNT_W = $clog2(TIMEOUT);

  localparam logic [2:0]       OP_LAST  = 3'(NUM_OPS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] MODE_OP  = 2'd0;
  localparam logic [1:0] MODE_RES = 2'd1;
  localparam logic [1:0] MODE_ERR = 2'd2;

  localparam logic [RES_W-1:0] CODE_ALU_ERR = RES_W'(1);
  localparam logic [RES_W-1:0] CODE_TIMEOUT = RES_W'(2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_SHOW  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_sel_q, op_sel_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic              alu_start_q, alu_start_d;
  logic              busy_q, busy_d;
  logic [1:0]        disp_mode_q, disp_mode_d;
  logic [RES_W-1:0]  disp_val_q, disp_val_d;

  // Scroll helper signals.
  logic       scroll_req;
  logic [2:0] op_scrolled;
  logic       front_panel_state;

  // Scroll decode: a lone up or down pulse moves the selection with wrap;
  // both together cancel and are treated as no scroll at all.
  always_comb begin
    scroll_req  = up_p ^ down_p;
    op_scrolled = op_sel_q;
    if (up_p && !down_p) begin
      op_scrolled = (op_sel_q == OP_LAST) ? 3'd0 : op_sel_q + 3'd1;
    end else if (down_p && !up_p) begin
      op_scrolled = (op_sel_q == 3'd0) ? OP_LAST : op_sel_q - 3'd1;
    end
  end

  // States in which the front panel (enter, scroll) is listened to.
  always_comb begin
    front_panel_state = (state_q == S_IDLE) || (state_q == S_SHOW) ||
                        (state_q == S_ERR);
  end

  // Next-state and next-output logic; clear beats enter beats scroll.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_sel_d    = op_sel_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    disp_mode_d = disp_mode_q;
    disp_val_d  = disp_val_q;

    if (clear_p) begin
      // Abandons any in-flight ALU operation; a later done is ignored in IDLE.
      state_d     = S_IDLE;
      cnt_d       = '0;
      disp_mode_d = MODE_OP;
      disp_val_d  = '0;
    end else if (front_panel_state) begin
      if (enter_p) begin
        alu_a_d  = a;
        alu_b_d  = b;
        alu_op_d = op_sel_q;
        state_d  = S_ISSUE;
      end else if (scroll_req) begin
        op_sel_d    = op_scrolled;
        state_d     = S_IDLE;
        disp_mode_d = MODE_OP;
        disp_val_d  = '0;
      end
    end else begin
      case (state_q)
        S_ISSUE: begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
        S_WAIT: begin
          if (alu_done) begin
            cnt_d = '0;
            if (alu_err) begin
              state_d     = S_ERR;
              disp_mode_d = MODE_ERR;
              disp_val_d  = CODE_ALU_ERR;
            end else begin
              state_d     = S_SHOW;
              disp_mode_d = MODE_RES;
              disp_val_d  = alu_result;
            end
          end else if (cnt_q == CNT_LAST) begin
            // TIMEOUT cycles spent in WAIT without a done.
            cnt_d       = '0;
            state_d     = S_ERR;
            disp_mode_d = MODE_ERR;
            disp_val_d  = CODE_TIMEOUT;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Strobe and busy are registered copies of the upcoming state.
    alu_start_d = (state_d == S_ISSUE);
    busy_d      = (state_d == S_ISSUE) || (state_d == S_WAIT);
  end

  // State and output registers; reset aborts any operation immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_sel_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      alu_start_q <= 1'b0;
      busy_q      <= 1'b0;
      disp_mode_q <= MODE_OP;
      disp_val_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_sel_q    <= op_sel_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      alu_start_q <= alu_start_d;
      busy_q      <= busy_d;
      disp_mode_q <= disp_mode_d;
      disp_val_q  <= disp_val_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign alu_start = alu_start_q;
  assign op_sel    = op_sel_q;
  assign busy      = busy_q;
  assign disp_mode = disp_mode_q;
  assign disp_val  = disp_val_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// Testbench for calc_ctrl: directed scenarios plus a randomized run checked
// against a transaction-level reference model of the controller.
module tb_calc_ctrl;

  localparam int DATA_W  = 4;
  localparam int RES_W   = 8;
  localparam int NUM_OPS = 8;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] a = '0;
  logic [DATA_W-1:0] b = '0;
  logic              enter_p = 1'b0;
  logic              clear_p = 1'b0;
  logic              up_p = 1'b0;
  logic              down_p = 1'b0;
  logic              alu_done = 1'b0;
  logic [RES_W-1:0]  alu_result = '0;
  logic              alu_err = 1'b0;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_op;
  logic              alu_start;
  logic [2:0]        op_sel;
  logic              busy;
  logic [1:0]        disp_mode;
  logic [RES_W-1:0]  disp_val;

  int checks = 0;
  int errors = 0;

  calc_ctrl #(
    .DATA_W (DATA_W),
    .RES_W  (RES_W),
    .NUM_OPS(NUM_OPS),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .enter_p   (enter_p),
    .clear_p   (clear_p),
    .up_p      (up_p),
    .down_p    (down_p),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_start (alu_start),
    .alu_done  (alu_done),
    .alu_result(alu_result),
    .alu_err   (alu_err),
    .op_sel    (op_sel),
    .busy      (busy),
    .disp_mode (disp_mode),
    .disp_val  (disp_val)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (transaction level) ----------------
  localparam int PH_IDLE = 0, PH_ISSUE = 1, PH_WAIT = 2, PH_SHOW = 3, PH_ERR = 4;
  int                m_phase;
  int                m_waited;
  logic [2:0]        m_op_sel;
  logic [2:0]        m_alu_op;
  logic [DATA_W-1:0] m_a;
  logic [DATA_W-1:0] m_b;
  logic [1:0]        m_dm;
  logic [RES_W-1:0]  m_dv;

  task automatic model_reset();
    m_phase = PH_IDLE; m_waited = 0; m_op_sel = '0; m_alu_op = '0;
    m_a = '0; m_b = '0; m_dm = '0; m_dv = '0;
  endtask

  // Apply one clock edge worth of front-panel/ALU inputs to the model.
  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else if (clear_p) begin
      m_phase = PH_IDLE; m_waited = 0; m_dm = 0; m_dv = 0;
    end else if (m_phase == PH_IDLE || m_phase == PH_SHOW || m_phase == PH_ERR) begin
      if (enter_p) begin
        m_a = a; m_b = b; m_alu_op = m_op_sel; m_phase = PH_ISSUE;
      end else if (up_p != down_p) begin
        if (up_p) m_op_sel = 3'((int'(m_op_sel) + 1) % NUM_OPS);
        else      m_op_sel = 3'((int'(m_op_sel) + NUM_OPS - 1) % NUM_OPS);
        m_phase = PH_IDLE; m_dm = 0; m_dv = 0;
      end
    end else if (m_phase == PH_ISSUE) begin
      m_phase = PH_WAIT; m_waited = 0;
    end else begin
      if (alu_done) begin
        m_phase = alu_err ? PH_ERR : PH_SHOW;
        m_dm    = alu_err ? 2'd2 : 2'd1;
        m_dv    = alu_err ? RES_W'(1) : alu_result;
      end else begin
        m_waited = m_waited + 1;
        if (m_waited == TIMEOUT) begin
          m_phase = PH_ERR; m_dm = 2; m_dv = RES_W'(2);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse(input logic c, input logic e, input logic u, input logic d);
    clear_p = c; enter_p = e; up_p = u; down_p = d;
    tick();
    clear_p = 0; enter_p = 0; up_p = 0; down_p = 0;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    rst_n = 0;
    model_reset();
    tick(); tick();
    checks++;
    if ({alu_a, alu_b, alu_op, alu_start, busy} !== '0) begin
      errors++;
      $display("FAIL reset_alu got a=%0h b=%0h op=%0h start=%0b busy=%0b required all 0",
               alu_a, alu_b, alu_op, alu_start, busy);
    end
    checks++;
    if ({op_sel, disp_mode, disp_val} !== '0) begin
      errors++;
      $display("FAIL reset_disp got op_sel=%0h mode=%0h val=%0h required all 0",
               op_sel, disp_mode, disp_val);
    end
    rst_n = 1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_scroll();
    for (int i = 0; i < 9; i++) pulse(0, 0, 1, 0);
    checks++;
    if (op_sel !== 3'd1) begin
      errors++; $display("FAIL scroll_up_wrap got %0d required 1", op_sel);
    end
    pulse(0, 0, 0, 1);
    checks++;
    if (op_sel !== 3'd0) begin
      errors++; $display("FAIL scroll_down got %0d required 0", op_sel);
    end
    pulse(0, 0, 0, 1);
    checks++;
    if (op_sel !== 3'd7) begin
      errors++; $display("FAIL scroll_down_wrap got %0d required 7", op_sel);
    end
    pulse(0, 0, 1, 1);
    checks++;
    if (op_sel !== 3'd7) begin
      errors++; $display("FAIL scroll_both got %0d required 7", op_sel);
    end
    $display("test_scroll done op_sel=%0d", op_sel);
  endtask

  task automatic test_compute();
    for (int i = 0; i < 3; i++) pulse(0, 0, 1, 0);   // 7 -> 0 -> 1 -> 2
    a = 4'd5; b = 4'd3;
    pulse(0, 1, 0, 0);
    checks++;
    if ({alu_start, busy, alu_op, alu_a, alu_b} !== {1'b1, 1'b1, 3'd2, 4'd5, 4'd3}) begin
      errors++;
      $display("FAIL issue got start=%0b busy=%0b op=%0d a=%0d b=%0d required 1 1 2 5 3",
               alu_start, busy, alu_op, alu_a, alu_b);
    end
    tick();
    checks++;
    if ({alu_start, busy} !== 2'b01) begin
      errors++; $display("FAIL start_one_cycle got start=%0b busy=%0b required 0 1", alu_start, busy);
    end
    a = 4'd9;
    pulse(0, 1, 0, 0);
    checks++;
    if ({alu_start, alu_a} !== {1'b0, 4'd5}) begin
      errors++; $display("FAIL wait_ignore got start=%0b a=%0d required 0 5", alu_start, alu_a);
    end
    tick();
    alu_done = 1; alu_err = 0; alu_result = 8'd8;
    tick();
    alu_done = 0;
    checks++;
    if ({disp_mode, disp_val, busy} !== {2'd1, 8'd8, 1'b0}) begin
      errors++;
      $display("FAIL result got mode=%0d val=%0d busy=%0b required 1 8 0", disp_mode, disp_val, busy);
    end
    $display("test_compute done val=%0d", disp_val);
  endtask

  task automatic test_clear_enter();
    pulse(1, 1, 0, 0);
    checks++;
    if ({alu_start, busy, disp_mode, disp_val} !== '0) begin
      errors++;
      $display("FAIL clear_enter got start=%0b busy=%0b mode=%0d val=%0d required all 0",
               alu_start, busy, disp_mode, disp_val);
    end
    tick();
    checks++;
    if (alu_start !== 1'b0) begin
      errors++; $display("FAIL clear_no_start got %0b required 0", alu_start);
    end
    $display("test_clear_enter done");
  endtask

  task automatic test_alu_err();
    a = 4'd7; b = 4'd0;
    pulse(0, 1, 0, 0);
    tick();
    alu_done = 1; alu_err = 1; alu_result = 8'hAB;
    tick();
    alu_done = 0; alu_err = 0;
    checks++;
    if ({disp_mode, disp_val, busy} !== {2'd2, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL alu_err got mode=%0d val=%0d busy=%0b required 2 1 0", disp_mode, disp_val, busy);
    end
    pulse(0, 0, 1, 0);
    checks++;
    if ({disp_mode, op_sel} !== {2'd0, 3'd3}) begin
      errors++; $display("FAIL err_scroll got mode=%0d op_sel=%0d required 0 3", disp_mode, op_sel);
    end
    $display("test_alu_err done");
  endtask

  task automatic test_timeout();
    pulse(0, 1, 0, 0);
    tick();   // start deasserts here
    for (int i = 1; i <= TIMEOUT; i++) begin
      tick();
      if (i == TIMEOUT - 1) begin
        checks++;
        if ({busy, disp_mode} !== {1'b1, 2'd0}) begin
          errors++; $display("FAIL timeout_early got busy=%0b mode=%0d required 1 0", busy, disp_mode);
        end
      end
    end
    checks++;
    if ({disp_mode, disp_val, busy} !== {2'd2, 8'd2, 1'b0}) begin
      errors++;
      $display("FAIL timeout got mode=%0d val=%0d busy=%0b required 2 2 0", disp_mode, disp_val, busy);
    end
    alu_done = 1; alu_result = 8'h55;
    tick();
    alu_done = 0;
    checks++;
    if ({disp_mode, disp_val} !== {2'd2, 8'd2}) begin
      errors++; $display("FAIL late_done got mode=%0d val=%0d required 2 2", disp_mode, disp_val);
    end
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid();
    pulse(0, 1, 0, 0);
    tick();
    #2;
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if ({op_sel, alu_a, alu_b, alu_op, alu_start, busy, disp_mode, disp_val} !== '0) begin
      errors++;
      $display("FAIL async_reset got op_sel=%0d a=%0d b=%0d op=%0d start=%0b busy=%0b mode=%0d val=%0d required all 0",
               op_sel, alu_a, alu_b, alu_op, alu_start, busy, disp_mode, disp_val);
    end
    tick();
    rst_n = 1;
    alu_done = 1; alu_result = 8'h77;
    tick();
    alu_done = 0;
    checks++;
    if ({busy, disp_mode, disp_val} !== '0) begin
      errors++;
      $display("FAIL post_reset_done got busy=%0b mode=%0d val=%0d required 0 0 0", busy, disp_mode, disp_val);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    int done_pct;
    for (int i = 0; i < 3000; i++) begin
      done_pct   = ((i / 250) % 2 == 0) ? 30 : 0;
      a          = DATA_W'($urandom);
      b          = DATA_W'($urandom);
      clear_p    = ($urandom_range(0, 19) == 0);
      enter_p    = ($urandom_range(0, 5) == 0);
      up_p       = ($urandom_range(0, 5) == 0);
      down_p     = ($urandom_range(0, 5) == 0);
      alu_done   = ($urandom_range(0, 99) < done_pct);
      alu_err    = ($urandom_range(0, 3) == 0);
      alu_result = RES_W'($urandom);
      tick();
      checks++;
      if ({op_sel, alu_a, alu_b, alu_op, alu_start, busy, disp_mode, disp_val} !==
          {m_op_sel, m_a, m_b, m_alu_op, m_phase == PH_ISSUE,
           (m_phase == PH_ISSUE) || (m_phase == PH_WAIT), m_dm, m_dv}) begin
        errors++;
        $display("FAIL random cyc=%0d got op_sel=%0d a=%0d b=%0d op=%0d start=%0b busy=%0b mode=%0d val=%0h required %0d %0d %0d %0d %0b %0b %0d %0h",
                 i, op_sel, alu_a, alu_b, alu_op, alu_start, busy, disp_mode, disp_val,
                 m_op_sel, m_a, m_b, m_alu_op, m_phase == PH_ISSUE,
                 (m_phase == PH_ISSUE) || (m_phase == PH_WAIT), m_dm, m_dv);
      end
    end
    clear_p = 0; enter_p = 0; up_p = 0; down_p = 0; alu_done = 0; alu_err = 0;
    $display("test_random done");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scroll();
    test_compute();
    test_clear_enter();
    test_alu_err();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
